// File: rtl/dual_chan_arb.sv
// Fixed-priority arbiter sharing two identical channels among eight requesters.
// Top-two priority search per cycle, registered grants, per-channel hold timeout with lockout.
module dual_chan_arb #(
  parameter int MAX_HOLD = 16,
  parameter int HW       = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [1:0] busy,
  output logic [2:0] owner0,
  output logic [2:0] owner1,
  output logic [1:0] tout,
  output logic [7:0] locked
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [HW-1:0] MAX_H = HW'(MAX_HOLD);

  state_t        state_q [2];
  state_t        state_d [2];
  logic [2:0]    own_q   [2];
  logic [2:0]    own_d   [2];
  logic [HW-1:0] hcnt_q  [2];
  logic [HW-1:0] hcnt_d  [2];
  logic [7:0]    gnt_d;
  logic [7:0]    locked_d;
  logic [1:0]    tout_d;
  logic [7:0]    cand;
  logic [7:0]    cand2;
  logic          p1_v, p2_v;
  logic [2:0]    p1, p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        state_q[c] <= IDLE;
        own_q[c]   <= '0;
        hcnt_q[c]  <= '0;
      end
      gnt    <= '0;
      locked <= '0;
      tout   <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        state_q[c] <= state_d[c];
        own_q[c]   <= own_d[c];
        hcnt_q[c]  <= hcnt_d[c];
      end
      gnt    <= gnt_d;
      locked <= locked_d;
      tout   <= tout_d;
    end
  end

  // Release/timeout only see channels busy before the edge; allocation only
  // uses channels idle before the edge, so a freed channel rests one cycle.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      state_d[c] = state_q[c];
      own_d[c]   = own_q[c];
      hcnt_d[c]  = hcnt_q[c];
    end
    tout_d   = '0;
    locked_d = locked & req;
    gnt_d    = '0;

    cand = req & ~gnt & ~locked;
    p1_v = 1'b0;
    p1   = '0;
    for (int i = 0; i < 8; i++) begin
      if (cand[i]) begin
        p1_v = 1'b1;
        p1   = 3'(i);
      end
    end
    cand2 = cand;
    if (p1_v) cand2[p1] = 1'b0;
    p2_v = 1'b0;
    p2   = '0;
    for (int i = 0; i < 8; i++) begin
      if (cand2[i]) begin
        p2_v = 1'b1;
        p2   = 3'(i);
      end
    end

    for (int c = 0; c < 2; c++) begin
      if (state_q[c] == BUSY) begin
        if (!req[own_q[c]]) begin
          state_d[c] = IDLE;
          hcnt_d[c]  = '0;
        end else if (MAX_HOLD != 0 && hcnt_q[c] == MAX_H) begin
          state_d[c]          = IDLE;
          hcnt_d[c]           = '0;
          tout_d[c]           = 1'b1;
          locked_d[own_q[c]]  = 1'b1;
        end else if (MAX_HOLD != 0) begin
          hcnt_d[c] = hcnt_q[c] + 1'b1;
        end
      end
    end

    if (state_q[0] == IDLE && state_q[1] == IDLE) begin
      if (p1_v) begin
        state_d[0] = BUSY;
        own_d[0]   = p1;
        hcnt_d[0]  = HW'(1);
      end
      if (p2_v) begin
        state_d[1] = BUSY;
        own_d[1]   = p2;
        hcnt_d[1]  = HW'(1);
      end
    end else if (state_q[0] == IDLE && p1_v) begin
      state_d[0] = BUSY;
      own_d[0]   = p1;
      hcnt_d[0]  = HW'(1);
    end else if (state_q[1] == IDLE && p1_v) begin
      state_d[1] = BUSY;
      own_d[1]   = p1;
      hcnt_d[1]  = HW'(1);
    end

    for (int c = 0; c < 2; c++) begin
      if (state_d[c] == BUSY) gnt_d[own_d[c]] = 1'b1;
    end
  end

  assign busy   = {state_q[1] == BUSY, state_q[0] == BUSY};
  assign owner0 = own_q[0];
  assign owner1 = own_q[1];

endmodule

// File: tb/tb_dual_chan_arb.sv
// Directed self-checking bench for dual_chan_arb with a 4-cycle hold limit.
module tb_dual_chan_arb;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [1:0] busy;
  logic [2:0] owner0;
  logic [2:0] owner1;
  logic [1:0] tout;
  logic [7:0] locked;

  int n_asserts = 0;
  int n_fail    = 0;

  dual_chan_arb #(.MAX_HOLD(4), .HW(3)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .gnt    (gnt),
    .busy   (busy),
    .owner0 (owner0),
    .owner1 (owner1),
    .tout   (tout),
    .locked (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b1;
    req   = 8'h00;

    // Reset asserted mid-cycle must clear outputs without an edge
    #3 rst_n = 1'b0;
    #1;
    check_output("rst_gnt",    gnt,           8'h00);
    check_output("rst_busy",   {6'd0, busy},  8'h00);
    check_output("rst_owner0", {5'd0, owner0}, 8'h00);
    check_output("rst_owner1", {5'd0, owner1}, 8'h00);
    check_output("rst_tout",   {6'd0, tout},  8'h00);
    check_output("rst_locked", locked,        8'h00);
    cyc(2);
    rst_n = 1'b1;

    req = 8'h04;
    cyc(1);
    check_output("single_gnt",    gnt,            8'h04);
    check_output("single_busy",   {6'd0, busy},   8'h01);
    check_output("single_owner0", {5'd0, owner0}, 8'h02);

    req = 8'h00;
    cyc(1);
    check_output("single_rel_gnt", gnt, 8'h00);
    cyc(1);

    req = 8'hA5;
    cyc(1);
    check_output("pair_gnt",    gnt,            8'hA0);
    check_output("pair_owner0", {5'd0, owner0}, 8'h07);
    check_output("pair_owner1", {5'd0, owner1}, 8'h05);
    check_output("pair_busy",   {6'd0, busy},   8'h03);
    cyc(1);
    check_output("pair_hold_gnt", gnt, 8'hA0);

    req = 8'h25;
    cyc(1);
    check_output("handoff1_gnt",  gnt,          8'h20);
    check_output("handoff1_busy", {6'd0, busy}, 8'h02);
    cyc(1);
    check_output("handoff2_gnt",    gnt,            8'h24);
    check_output("handoff2_owner0", {5'd0, owner0}, 8'h02);
    cyc(1);
    check_output("ch1_tout_gnt",    gnt,          8'h04);
    check_output("ch1_tout_pulse",  {6'd0, tout}, 8'h02);
    check_output("ch1_tout_locked", locked,       8'h20);

    req = 8'h00;
    cyc(1);
    check_output("clear_gnt",    gnt,          8'h00);
    check_output("clear_locked", locked,       8'h00);
    check_output("clear_tout",   {6'd0, tout}, 8'h00);
    cyc(1);

    req = 8'h08;
    for (int k = 0; k < 4; k++) begin
      cyc(1);
      check_output($sformatf("hold_gnt_%0d", k),  gnt,          8'h08);
      check_output($sformatf("hold_tout_%0d", k), {6'd0, tout}, 8'h00);
    end
    cyc(1);
    check_output("to_gnt",    gnt,          8'h00);
    check_output("to_tout",   {6'd0, tout}, 8'h01);
    check_output("to_locked", locked,       8'h08);
    cyc(1);
    check_output("to_pulse_end", {6'd0, tout}, 8'h00);
    check_output("locked_no_gnt", gnt,         8'h00);
    cyc(2);
    check_output("locked_still_gnt", gnt,    8'h00);
    check_output("locked_still",     locked, 8'h08);

    req = 8'h00;
    cyc(1);
    check_output("unlock", locked, 8'h00);
    req = 8'h08;
    cyc(1);
    check_output("regrant_gnt",    gnt,            8'h08);
    check_output("regrant_owner0", {5'd0, owner0}, 8'h03);

    // Drop the request on the edge where the hold count reaches its limit
    cyc(3);
    check_output("pre_limit_gnt", gnt, 8'h08);
    req = 8'h00;
    cyc(1);
    check_output("rel_at_to_tout",   {6'd0, tout}, 8'h00);
    check_output("rel_at_to_locked", locked,       8'h00);
    check_output("rel_at_to_busy",   {6'd0, busy}, 8'h00);
    check_output("rel_at_to_gnt",    gnt,          8'h00);
    cyc(1);

    req = 8'hC0;
    cyc(1);
    check_output("both_busy", {6'd0, busy}, 8'h03);
    check_output("both_gnt",  gnt,          8'hC0);
    #2 rst_n = 1'b0;
    #1;
    check_output("async_gnt",  gnt,          8'h00);
    check_output("async_busy", {6'd0, busy}, 8'h00);
    req = 8'h12;
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(1);
    check_output("post_rst_gnt",    gnt,            8'h12);
    check_output("post_rst_owner0", {5'd0, owner0}, 8'h04);
    check_output("post_rst_owner1", {5'd0, owner1}, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/dual_chan_arb.md
# dual_chan_arb

Sequential arbiter that shares two identical downstream channels among eight requesters using fixed priority (requester 7 highest). It performs a top-two priority search each cycle, registers the grants, and holds each grant until the owner releases it or a hold timeout expires. It sits between eight requesting units and a two-port shared resource, such as a dual-ported buffer or two bus lanes, and drives that resource's channel selects.

## Interface
- MAX_HOLD, default 16: maximum consecutive cycles a grant may be held. 0 disables the timeout.
- HW, default 5: hold-counter width. Must satisfy 2^HW > MAX_HOLD.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous and active-low.
- req  input  8  request per requester. Level-sensitive: a requester holds req high for as long as it wants the grant.
- gnt  output  8  registered grant per requester. At most two bits are set.
- busy  output  2  busy[c] is high while channel c is owned.
- owner0, owner1  output  3 each  index of the requester that owns channel 0 or channel 1. Valid only while the matching busy bit is high.
- tout  output  2  one-cycle pulse when channel c is revoked by timeout.
- locked  output  8  requesters currently barred after a timeout.

## Operation
- Per-channel FSM with two states, IDLE and BUSY. Each channel has its own owner register and hold counter hcnt (HW bits).
- Candidate set each cycle: cand = req & ~gnt & ~locked.
- Allocation is evaluated at each rising edge using only channels that are IDLE before that edge:
  - p1 = highest set index in cand; p2 = next highest set index below p1.
  - Both channels IDLE: p1 goes to channel 0 and p2 goes to channel 1 (only if p2 exists).
  - Exactly one channel IDLE: p1 goes to that channel.
  - cand empty: no change.
- Grant: channel goes IDLE -> BUSY, owner is loaded, hcnt = 1, gnt[owner] is set.
- Release: while BUSY, if req[owner] is sampled low, the channel goes BUSY -> IDLE, gnt[owner] clears and hcnt is cleared.
  - A freed channel is not re-granted on the same edge. It spends at least one cycle in IDLE.
- Timeout (MAX_HOLD > 0): while BUSY, hcnt increments each cycle with req[owner] high.
  - When hcnt == MAX_HOLD and req[owner] is still high, the channel goes BUSY -> IDLE and gnt[owner] clears.
  - On the same edge, locked[owner] sets and tout[c] pulses for one cycle.
- locked[i] clears at the edge where req[i] is sampled low. A locked requester is never a candidate.
- A requester never owns both channels, because gnt excludes it from cand.
- Release and timeout on the same edge: release wins. locked is not set and tout does not pulse.
- Both channels freed on the same edge: each is handled independently. Both stay IDLE for one cycle.

## Timing
- Reset (rst_n low, asynchronous): both FSMs go to IDLE. gnt = 0, busy = 0, owner0 = owner1 = 0, tout = 0, locked = 0, hcnt = 0.
- Reset mid-operation drops all grants immediately, without waiting for a clock edge.
- Grant latency: req rises before edge k with a channel IDLE and the requester top-ranked -> gnt high after edge k, i.e. 1 cycle.
- Release latency: req falls before edge k -> gnt low after edge k. The channel becomes grantable at edge k+1.
- Hold bound: gnt[i] is high for at most MAX_HOLD consecutive cycles.
- All outputs are registered. There are no combinational paths from req to any output.

## Test plan
- Reset and single request:
  - Stimulus: assert rst_n low mid-cycle, then release it; raise req = 8'h04.
  - Required response: all outputs 0 immediately on reset. One edge after the request: gnt = 8'h04, busy = 2'b01, owner0 = 2.
- Simultaneous requests from idle:
  - Stimulus: req = 8'hA5 with both channels IDLE.
  - Required response: gnt = 8'hA0, owner0 = 7, owner1 = 5. Next cycle gnt is unchanged (the grants are held).
- Release handoff:
  - Stimulus: from the previous state, drop req[7].
  - Required response: edge 1: gnt = 8'h20, busy = 2'b10. Edge 2: channel 0 is granted to requester 2, so gnt = 8'h24.
- Timeout and lock (MAX_HOLD = 4):
  - Stimulus: hold req = 8'h08 continuously.
  - Required response: gnt[3] high for exactly 4 cycles, then tout[0] pulses and locked = 8'h08. No re-grant until req[3] drops for one cycle; the next rise is then granted normally.
- Release at timeout:
  - Stimulus: drop req on the same edge where hcnt reaches MAX_HOLD.
  - Required response: tout = 0, locked = 0, channel goes IDLE.
- Async reset mid-grant:
  - Stimulus: pull rst_n low while busy = 2'b11.
  - Required response: gnt = 0 and busy = 0 without a clock edge. After reset is released, reallocation follows normal priority order.
